// File: rtl/dclk_pkg.sv
// dclk_pkg: shared channel constants and sequencer state type
package dclk_pkg;
  localparam int NUM_CH = 4;
  localparam int SEL_W = 2;
  typedef enum logic [1:0] {IDLE, DRAIN, SWITCH, SETTLE} seq_state_t;
endpackage

// File: rtl/sel_sequencer_if.sv
// sel_sequencer_if: request handshake, scan control and router-facing select bundle
interface sel_sequencer_if;
  import dclk_pkg::*;
  logic             req_valid;
  logic [SEL_W-1:0] req_sel;
  logic             req_ready;
  logic             scan_en;
  logic [NUM_CH-1:0] chan_mask;
  logic [SEL_W-1:0] sell;
  logic             quiesce;
  logic             busy;
  logic             switch_done;
  modport master (
    output req_valid, req_sel, scan_en, chan_mask,
    input  req_ready, sell, quiesce, busy, switch_done
  );
  modport slave (
    input  req_valid, req_sel, scan_en, chan_mask,
    output req_ready, sell, quiesce, busy, switch_done
  );
endinterface

// File: rtl/sel_next_pick.sv
// sel_next_pick: first eligible channel after cur in rotating order, cur itself excluded
module sel_next_pick
  import dclk_pkg::*;
(
  input  logic [SEL_W-1:0]  cur,
  input  logic [NUM_CH-1:0] mask,
  output logic              found,
  output logic [SEL_W-1:0]  next
);
  logic [SEL_W-1:0] c1, c2, c3;
  // search cur+1, cur+2, cur+3 with natural 2-bit wrap
  always_comb begin
    c1 = cur + SEL_W'(1);
    c2 = cur + SEL_W'(2);
    c3 = cur + SEL_W'(3);
    found = mask[c1] | mask[c2] | mask[c3];
    next = mask[c1] ? c1 : mask[c2] ? c2 : c3;
  end
endmodule

// File: rtl/sel_sequencer.sv
// sel_sequencer: quiesce/switch/settle sequencing of the router channel select
module sel_sequencer
  import dclk_pkg::*;
#(
  parameter int GUARD_CYC  = 4,
  parameter int SETTLE_CYC = 8,
  parameter int DWELL_CYC  = 256,
  parameter int CNT_W      = 16
) (
  input logic            clk_in,
  input logic            rst,
  sel_sequencer_if.slave bus
);
  localparam logic [CNT_W-1:0] GUARD_LD  = CNT_W'(GUARD_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] DWELL_END = CNT_W'(DWELL_CYC - 1);
  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] sell_q, sell_d, target_q, target_d, pick_next;
  logic             quiesce_q, quiesce_d, busy_q, busy_d, done_q, done_d;
  logic             take, pick_found;
  sel_next_pick u_pick (
    .cur   (sell_q),
    .mask  (bus.chan_mask),
    .found (pick_found),
    .next  (pick_next)
  );
  assign bus.req_ready   = (state_q == IDLE) & rst;
  assign take            = bus.req_valid & bus.req_ready;
  assign bus.sell        = sell_q;
  assign bus.quiesce     = quiesce_q;
  assign bus.busy        = busy_q;
  assign bus.switch_done = done_q;
  // next state: one counter serves dwell in IDLE, guard in DRAIN, settle in SETTLE
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sell_d   = sell_q;
    target_d = target_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (take) begin
          cnt_d = '0;
          if (bus.req_sel != sell_q) begin
            state_d  = DRAIN;
            target_d = bus.req_sel;
            cnt_d    = GUARD_LD;
          end else begin
            done_d = 1'b1;
          end
        end else if (bus.scan_en) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == DWELL_END) begin
            cnt_d = '0;
            if (pick_found) begin
              state_d  = DRAIN;
              target_d = pick_next;
              cnt_d    = GUARD_LD;
            end
          end
        end else begin
          cnt_d = '0;
        end
      end
      DRAIN: begin
        state_d = (cnt_q == '0) ? SWITCH : DRAIN;
        cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - CNT_W'(1);
      end
      SWITCH: begin
        state_d = SETTLE;
        sell_d  = target_q;
        cnt_d   = SETTLE_LD;
      end
      SETTLE: begin
        state_d = (cnt_q == '0) ? IDLE : SETTLE;
        done_d  = (cnt_q == '0);
        cnt_d   = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
      end
    endcase
    quiesce_d = (state_d != IDLE);
    busy_d    = (state_d != IDLE);
  end
  // register state, counter and all outputs; reset forces sell back to channel 0
  always_ff @(posedge clk_in) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sell_q    <= '0;
      target_q  <= '0;
      quiesce_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sell_q    <= sell_d;
      target_q  <= target_d;
      quiesce_q <= quiesce_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end
endmodule

// File: tb/tb_sel_sequencer.sv
// tb_sel_sequencer: table vectors, corner sequences and random traffic against a timeline model
module tb_sel_sequencer;
  localparam int G  = 4;
  localparam int S  = 8;
  localparam int DW = 256;
  logic clk_in = 1'b0;
  logic rst = 1'b0;
  sel_sequencer_if bus ();
  sel_sequencer #(.GUARD_CYC(G), .SETTLE_CYC(S), .DWELL_CYC(DW), .CNT_W(16)) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus)
  );
  always #5 clk_in = ~clk_in;
  int n_vec = 0;
  int n_err = 0;
  int m_sell = 0;
  int m_tgt = 0;
  int m_el = -1;
  int m_dw = 0;
  bit m_done = 1'b0;
  typedef struct {
    bit         r;
    bit         v;
    logic [1:0] sel;
    int         reps;
    logic [5:0] exp;
  } vec_t;
  vec_t tbl[$];
  function automatic logic [5:0] act();
    return {bus.req_ready, bus.busy, bus.quiesce, bus.switch_done, bus.sell};
  endfunction
  function automatic logic [5:0] mexp();
    return {(m_el < 0) && rst, m_el >= 0, m_el >= 0, m_done, 2'(m_sell)};
  endfunction
  task automatic chk(string name, logic [5:0] a, logic [5:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s at %0t: got %b want %b (ready,busy,quiesce,done,sell)", name, $time, a, e);
    end
  endtask
  // timeline model: a switch is a fixed-length event measured in cycles since acceptance
  task automatic model_step();
    bit hit;
    m_done = 1'b0;
    if (!rst) begin
      m_sell = 0; m_el = -1; m_dw = 0; m_tgt = 0;
    end else if (m_el >= 0) begin
      m_el++;
      if (m_el == G + 1) m_sell = m_tgt;
      if (m_el == G + 1 + S) begin
        m_el = -1; m_done = 1'b1; m_dw = 0;
      end
    end else if (bus.req_valid) begin
      m_dw = 0;
      if (int'(bus.req_sel) == m_sell) m_done = 1'b1;
      else begin
        m_tgt = int'(bus.req_sel); m_el = 0;
      end
    end else if (bus.scan_en) begin
      if (m_dw == DW - 1) begin
        m_dw = 0;
        hit = 1'b0;
        for (int k = 1; k < 4; k++)
          if (!hit && bus.chan_mask[(m_sell + k) % 4]) begin
            hit = 1'b1; m_tgt = (m_sell + k) % 4; m_el = 0;
          end
      end else m_dw++;
    end else m_dw = 0;
  endtask
  task automatic step(bit r, bit v, logic [1:0] s);
    rst = r;
    bus.req_valid = v;
    bus.req_sel = s;
    @(posedge clk_in);
    model_step();
    #1;
    chk("model", act(), mexp());
  endtask
  task automatic steps(int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 2'd0);
  endtask
  initial begin
    bit seen;
    bit rr, vv;
    bus.req_valid = 1'b0;
    bus.req_sel = 2'd0;
    bus.scan_en = 1'b0;
    bus.chan_mask = 4'b0000;
    tbl.push_back(vec_t'{1'b0, 1'b0, 2'd0, 2,  6'b000000});
    tbl.push_back(vec_t'{1'b1, 1'b1, 2'd2, 1,  6'b011000});
    tbl.push_back(vec_t'{1'b1, 1'b0, 2'd0, 3,  6'b011000});
    tbl.push_back(vec_t'{1'b1, 1'b0, 2'd0, 1,  6'b011000});
    tbl.push_back(vec_t'{1'b1, 1'b0, 2'd0, 1,  6'b011010});
    tbl.push_back(vec_t'{1'b1, 1'b0, 2'd0, 7,  6'b011010});
    tbl.push_back(vec_t'{1'b1, 1'b0, 2'd0, 1,  6'b100110});
    tbl.push_back(vec_t'{1'b1, 1'b0, 2'd0, 1,  6'b100010});
    tbl.push_back(vec_t'{1'b1, 1'b1, 2'd2, 1,  6'b100110});
    tbl.push_back(vec_t'{1'b1, 1'b0, 2'd0, 1,  6'b100010});
    tbl.push_back(vec_t'{1'b1, 1'b1, 2'd1, 1,  6'b011010});
    tbl.push_back(vec_t'{1'b1, 1'b0, 2'd0, 13, 6'b100101});
    foreach (tbl[i]) begin
      for (int j = 0; j < tbl[i].reps; j++) step(tbl[i].r, tbl[i].v, tbl[i].sel);
      chk($sformatf("tbl%0d", i), act(), tbl[i].exp);
    end
    bus.scan_en = 1'b1;
    bus.chan_mask = 4'b1011;
    steps(DW + G + 1 + S);
    chk("scan_to3", act(), 6'b100111);
    steps(DW + G + 1 + S);
    chk("scan_to0", act(), 6'b100100);
    steps(DW + G + 1 + S);
    chk("scan_to1", act(), 6'b100101);
    bus.chan_mask = 4'b0010;
    seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      step(1'b1, 1'b0, 2'd0);
      seen |= bus.quiesce | bus.switch_done | (bus.sell != 2'd1);
    end
    chk("scan_none", {5'b00000, seen}, 6'b000000);
    bus.scan_en = 1'b0;
    steps(1);
    bus.scan_en = 1'b1;
    bus.chan_mask = 4'b1011;
    steps(DW - 1);
    step(1'b1, 1'b1, 2'd0);
    chk("req_wins", act(), 6'b011001);
    for (int i = 0; i < G + S; i++) step(1'b1, 1'b1, 2'd2);
    chk("hold_settle", act(), 6'b011000);
    step(1'b1, 1'b1, 2'd2);
    chk("hold_done", act(), 6'b100100);
    bus.scan_en = 1'b0;
    step(1'b1, 1'b1, 2'd2);
    chk("hold_accept", act(), 6'b011000);
    steps(G + S + 1);
    chk("hold_end", act(), 6'b100110);
    step(1'b1, 1'b1, 2'd3);
    steps(G + 2);
    chk("pre_rst", act(), 6'b011011);
    step(1'b0, 1'b0, 2'd0);
    chk("mid_rst", act(), 6'b000000);
    step(1'b1, 1'b1, 2'd1);
    chk("post_rst", act(), 6'b011000);
    steps(G + S + 1);
    chk("post_rst_done", act(), 6'b100101);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) bus.scan_en = ~bus.scan_en;
      if ($urandom_range(0, 49) == 0) bus.chan_mask = 4'($urandom_range(0, 15));
      rr = ($urandom_range(0, 149) != 0);
      vv = ($urandom_range(0, 7) == 0);
      step(rr, vv, 2'($urandom_range(0, 3)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
